// File: rtl/warp_imem_ahb.sv
//------------------------------------------------------------------------------
// Module   : warp_imem_ahb
// Brief    : AHB-Lite read-only fetch bridge; single 64-bit transfers, one
//            pending redirect slot. Optional error flag: WARP_IMEM_FAULT_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module warp_imem_ahb #(
  parameter int          ADDR_W    = 39,
  parameter logic [3:0]  HPROT_VAL = 4'b0010
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_imem_ren,
  input  logic [ADDR_W-1:0] i_imem_raddr,
  output logic              o_imem_valid,
  output logic [63:0]       o_imem_rdata,
  output logic [1:0]        o_htrans,
  output logic [ADDR_W-1:0] o_haddr,
  output logic              o_hwrite,
  output logic [2:0]        o_hsize,
  output logic [2:0]        o_hburst,
  output logic [3:0]        o_hprot,
  input  logic              i_hready,
  input  logic              i_hresp,
  input  logic [63:0]       i_hrdata
`ifdef WARP_IMEM_FAULT_EN
  ,
  output logic              o_imem_fault
`endif
);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_ADDR = 2'd1;
  localparam logic [1:0] c_ST_DATA = 2'd2;
  localparam logic [1:0] c_ST_ERR  = 2'd3;

  localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;

  logic [1:0]        r_state;
  logic              r_pend_vld;
  logic [ADDR_W-4:0] r_pend_line;
  logic [1:0]        r_htrans;
  logic [ADDR_W-1:0] r_haddr;
  logic              r_valid;
  logic [63:0]       r_rdata;
  logic [ADDR_W-4:0] w_req_line;
  logic [2:0]        w_unused_raddr_lo;

  assign w_req_line        = i_imem_raddr[ADDR_W-1:3];
  assign w_unused_raddr_lo = i_imem_raddr[2:0];

`ifdef WARP_IMEM_FAULT_EN
  logic r_fault;
  assign o_imem_fault = r_fault;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= c_ST_IDLE;
      r_pend_vld  <= 1'b0;
      r_pend_line <= '0;
      r_htrans    <= c_HTRANS_IDLE;
      r_haddr     <= '0;
      r_valid     <= 1'b0;
      r_rdata     <= '0;
`ifdef WARP_IMEM_FAULT_EN
      r_fault     <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
`ifdef WARP_IMEM_FAULT_EN
      r_fault <= 1'b0;
`endif
      case (r_state)
        c_ST_IDLE: begin
          // A held redirect goes first; a same-cycle request refills the slot.
          if (r_pend_vld) begin
            r_state    <= c_ST_ADDR;
            r_htrans   <= c_HTRANS_NONSEQ;
            r_haddr    <= {r_pend_line, 3'b000};
            r_pend_vld <= i_imem_ren;
            if (i_imem_ren) begin
              r_pend_line <= w_req_line;
            end
          end else if (i_imem_ren) begin
            r_state  <= c_ST_ADDR;
            r_htrans <= c_HTRANS_NONSEQ;
            r_haddr  <= {w_req_line, 3'b000};
          end
        end
        c_ST_ADDR: begin
          if (i_hready) begin
            r_state  <= c_ST_DATA;
            r_htrans <= c_HTRANS_IDLE;
          end
        end
        c_ST_DATA: begin
          if (i_hready) begin
            r_state <= c_ST_IDLE;
            r_valid <= 1'b1;
            r_rdata <= i_hrdata;
          end else if (i_hresp) begin
            r_state <= c_ST_ERR;
          end
        end
        c_ST_ERR: begin
          if (i_hready && i_hresp) begin
            r_state <= c_ST_IDLE;
            r_valid <= 1'b1;
`ifdef WARP_IMEM_FAULT_EN
            r_fault <= 1'b1;
            r_rdata <= '0;
`else
            r_rdata <= i_hrdata;
`endif
          end
        end
        default: begin
          r_state  <= c_ST_IDLE;
          r_htrans <= c_HTRANS_IDLE;
        end
      endcase

      // Requests arriving mid-transfer overwrite any older redirect.
      if ((r_state != c_ST_IDLE) && i_imem_ren) begin
        r_pend_vld  <= 1'b1;
        r_pend_line <= w_req_line;
      end
    end
  end

  assign o_imem_valid = r_valid;
  assign o_imem_rdata = r_rdata;
  assign o_htrans     = r_htrans;
  assign o_haddr      = r_haddr;
  assign o_hwrite     = 1'b0;
  assign o_hsize      = 3'b011;
  assign o_hburst     = 3'b000;
  assign o_hprot      = HPROT_VAL;

endmodule

`default_nettype wire

// File: tb/tb_warp_imem_ahb.sv
//------------------------------------------------------------------------------
// Module   : tb_warp_imem_ahb
// Brief    : Cycle-vector bench for warp_imem_ahb (honours WARP_IMEM_FAULT_EN).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_warp_imem_ahb;

  localparam logic [1:0] c_I  = 2'b00;
  localparam logic [1:0] c_NS = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic        ren;
  logic [38:0] raddr;
  logic        valid;
  logic [63:0] rdata;
  logic [1:0]  htrans;
  logic [38:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hready;
  logic        hresp;
  logic [63:0] hrdata;
`ifdef WARP_IMEM_FAULT_EN
  logic        fault;
  localparam logic [63:0] c_ERR_DATA = 64'h0;
`else
  localparam logic [63:0] c_ERR_DATA = 64'h5555555555555555;
`endif

  always #5 clk = ~clk;

  warp_imem_ahb #(.ADDR_W(39), .HPROT_VAL(4'b0010)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_imem_ren   (ren),
    .i_imem_raddr (raddr),
    .o_imem_valid (valid),
    .o_imem_rdata (rdata),
    .o_htrans     (htrans),
    .o_haddr      (haddr),
    .o_hwrite     (hwrite),
    .o_hsize      (hsize),
    .o_hburst     (hburst),
    .o_hprot      (hprot),
    .i_hready     (hready),
    .i_hresp      (hresp),
`ifdef WARP_IMEM_FAULT_EN
    .o_imem_fault (fault),
`endif
    .i_hrdata     (hrdata)
  );

  typedef struct {
    logic        ren;
    logic [38:0] raddr;
    logic        hready;
    logic        hresp;
    logic [63:0] hrdata;
    logic [1:0]  e_htrans;
    logic        e_chk_addr;
    logic [38:0] e_haddr;
    logic        e_valid;
    logic [63:0] e_rdata;
    logic        e_fault;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(logic r, logic [38:0] a, logic hr, logic hs, logic [63:0] hd,
                              logic [1:0] et, logic ec, logic [38:0] ea, logic ev,
                              logic [63:0] ed, logic ef);
    vec_t v;
    v.ren = r; v.raddr = a; v.hready = hr; v.hresp = hs; v.hrdata = hd;
    v.e_htrans = et; v.e_chk_addr = ec; v.e_haddr = ea; v.e_valid = ev;
    v.e_rdata = ed; v.e_fault = ef;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [38:0] a, input logic hr, input logic hs,
                       input logic [63:0] hd);
    ren = r; raddr = a; hready = hr; hresp = hs; hrdata = hd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 1'b1, 1'b0, '0);

    // Each row: inputs for this cycle, outputs expected in this same cycle.
    // zero-wait beat
    vecs.push_back(mk(1, 39'h4000000008, 1, 0, 64'h0011223344556677, c_I, 1, 39'h0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 64'h0011223344556677, c_NS, 1, 39'h4000000008, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 64'h0011223344556677, c_I, 1, 39'h4000000008, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 64'h0, c_I, 0, 0, 1, 64'h0011223344556677, 0));
    // wait states: 2 in address phase, 3 in data phase
    vecs.push_back(mk(1, 39'h4000000013, 1, 0, 0, c_I, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, c_NS, 1, 39'h4000000010, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, c_NS, 1, 39'h4000000010, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, c_NS, 1, 39'h4000000010, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 64'h1111111111111111, c_I, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 64'h1111111111111111, c_I, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 64'h1111111111111111, c_I, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 64'hDEADBEEFCAFEF00D, c_I, 0, 0, 0, 0, 0));
    // pending overwrite (first ren lands on a completion cycle)
    vecs.push_back(mk(1, 39'h4000000000, 1, 0, 0, c_I, 0, 0, 1, 64'hDEADBEEFCAFEF00D, 0));
    vecs.push_back(mk(1, 39'h4000000040, 1, 0, 0, c_NS, 1, 39'h4000000000, 0, 0, 0));
    vecs.push_back(mk(1, 39'h4000000080, 1, 0, 64'h0101010101010101, c_I, 1, 39'h4000000000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, c_I, 1, 39'h4000000000, 1, 64'h0101010101010101, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, c_NS, 1, 39'h4000000080, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 64'h0808080808080808, c_I, 1, 39'h4000000080, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, c_I, 1, 39'h4000000080, 1, 64'h0808080808080808, 0));
    // ren coinciding with a completion pulse
    vecs.push_back(mk(1, 39'h4000000008, 1, 0, 0, c_I, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, c_NS, 1, 39'h4000000008, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 64'h2222222222222222, c_I, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 39'h4000000010, 1, 0, 0, c_I, 0, 0, 1, 64'h2222222222222222, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, c_NS, 1, 39'h4000000010, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 64'h3333333333333333, c_I, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, c_I, 0, 0, 1, 64'h3333333333333333, 0));
    // error response, then a normal request
    vecs.push_back(mk(1, 39'h4000000100, 1, 0, 0, c_I, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, c_NS, 1, 39'h4000000100, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 64'h4444444444444444, c_I, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 64'h5555555555555555, c_I, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 39'h4000000108, 1, 0, 0, c_I, 0, 0, 1, c_ERR_DATA, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, c_NS, 1, 39'h4000000108, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 64'h6666666666666666, c_I, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, c_I, 0, 0, 1, 64'h6666666666666666, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, c_I, 0, 0, 0, 0, 0));

    repeat (2) step();
    rst = 1'b0;

    chk("reset_rdata", rdata, 64'h0);
    chk("hwrite", {63'h0, hwrite}, 64'h0);
    chk("hsize", {61'h0, hsize}, 64'h3);
    chk("hburst", {61'h0, hburst}, 64'h0);
    chk("hprot", {60'h0, hprot}, 64'h2);

    for (int i = 0; i < vecs.size(); i++) begin
      chk($sformatf("v%0d_htrans", i), {62'h0, htrans}, {62'h0, vecs[i].e_htrans});
      chk($sformatf("v%0d_valid", i), {63'h0, valid}, {63'h0, vecs[i].e_valid});
      if (vecs[i].e_chk_addr) chk($sformatf("v%0d_haddr", i), {25'h0, haddr}, {25'h0, vecs[i].e_haddr});
      if (vecs[i].e_valid) chk($sformatf("v%0d_rdata", i), rdata, vecs[i].e_rdata);
`ifdef WARP_IMEM_FAULT_EN
      chk($sformatf("v%0d_fault", i), {63'h0, fault}, {63'h0, vecs[i].e_fault});
`endif
      drive(vecs[i].ren, vecs[i].raddr, vecs[i].hready, vecs[i].hresp, vecs[i].hrdata);
      step();
    end

    // reset during data phase with a redirect pending
    drive(1, 39'h4000000200, 1, 0, 0);
    step();
    chk("rst_seq_ns", {62'h0, htrans}, {62'h0, c_NS});
    chk("rst_seq_addr", {25'h0, haddr}, {25'h0, 39'h4000000200});
    drive(0, 0, 1, 0, 0);
    step();
    drive(1, 39'h4000000208, 0, 0, 64'h7777777777777777);
    step();
    rst = 1'b1;
    drive(0, 0, 0, 0, 64'h7777777777777777);
    step();
    rst = 1'b0;
    drive(0, 0, 1, 0, 64'h7777777777777777);
    chk("post_rst_htrans", {62'h0, htrans}, {62'h0, c_I});
    chk("post_rst_haddr", {25'h0, haddr}, 64'h0);
    chk("post_rst_valid", {63'h0, valid}, 64'h0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("idle%0d_htrans", k), {62'h0, htrans}, {62'h0, c_I});
      chk($sformatf("idle%0d_valid", k), {63'h0, valid}, 64'h0);
    end
    drive(1, 39'h4000000300, 1, 0, 0);
    step();
    drive(0, 0, 1, 0, 64'h9999999999999999);
    chk("new_ns", {62'h0, htrans}, {62'h0, c_NS});
    chk("new_addr", {25'h0, haddr}, {25'h0, 39'h4000000300});
    step();
    chk("new_data_valid0", {63'h0, valid}, 64'h0);
    step();
    chk("new_valid", {63'h0, valid}, 64'h1);
    chk("new_rdata", rdata, 64'h9999999999999999);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
